// File: rtl/alu_wide_seq.sv
// Sequencer that chains two N-bit ALU passes (low slice, then high slice) into one
// 2N-bit add or subtract. Subtract is run as a + ~b + 1 so slices chain through carry.
module alu_wide_seq #(
  parameter int          N        = 8,
  parameter logic [3:0]  MODE_ADD = 4'b0000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           op_sub,
  input  logic           carry_in,
  input  logic [2*N-1:0] opa,
  input  logic [2*N-1:0] opb,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           zero,
  output logic [3:0]     alu_mode,
  output logic           alu_cin,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [N-1:0]     opa_hi_q;
  logic [N-1:0]     opb_hi_q;
  logic [N-1:0]     lo_q;
  logic [N-1:0]     alu_a_q;
  logic [N-1:0]     alu_b_q;
  logic             alu_cin_q;
  logic [2*N-1:0]   result_q;
  logic             carry_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [2*N-1:0]   wide_d;

  function automatic logic is_zero(input logic [2*N-1:0] v);
    return (v == {(2*N){1'b0}});
  endfunction

  assign wide_d = {alu_out, lo_q};

  // ALU drive values are registered on the edge entering LO/HI, so in HI the
  // carry-in register already holds the low-slice carry-out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      opa_hi_q  <= {N{1'b0}};
      opb_hi_q  <= {N{1'b0}};
      lo_q      <= {N{1'b0}};
      alu_a_q   <= {N{1'b0}};
      alu_b_q   <= {N{1'b0}};
      alu_cin_q <= 1'b0;
      result_q  <= {(2*N){1'b0}};
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_LO;
            busy_q    <= 1'b1;
            alu_a_q   <= opa[N-1:0];
            alu_b_q   <= op_sub ? ~opb[N-1:0] : opb[N-1:0];
            alu_cin_q <= op_sub | carry_in;
            opa_hi_q  <= opa[2*N-1:N];
            opb_hi_q  <= op_sub ? ~opb[2*N-1:N] : opb[2*N-1:N];
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LO: begin
          state_q   <= S_HI;
          lo_q      <= alu_out;
          alu_cin_q <= alu_cout;
          alu_a_q   <= opa_hi_q;
          alu_b_q   <= opb_hi_q;
        end
        S_HI: begin
          state_q   <= S_DONE;
          result_q  <= wide_d;
          carry_q   <= alu_cout;
          zero_q    <= is_zero(wide_d);
          done_q    <= 1'b1;
          alu_a_q   <= {N{1'b0}};
          alu_b_q   <= {N{1'b0}};
          alu_cin_q <= 1'b0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          alu_a_q   <= {N{1'b0}};
          alu_b_q   <= {N{1'b0}};
          alu_cin_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign alu_mode = MODE_ADD;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;

endmodule
